barrett_mu_gen: RTL and testbench
=================================

BARRETT_MU_GEN -- requirements
Module: barrett_mu_gen

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 in_valid  input  1  modulus request valid.
REQ-004 in_ready  output  1  block can accept a request; high only in IDLE.
REQ-005 q_in  input  64  modulus q.
REQ-006 out_valid  output  1  result valid; held until accepted.
REQ-007 out_ready  input  1  downstream (mod_mult configuration register) accepts result.
REQ-008 q_out  output  64  registered copy of the accepted q.
REQ-009 mu_out  output  64  Barrett constant floor(2^64 / q).
REQ-010 err  output  1  q < 2; qualified by out_valid.

Function
REQ-011 Purpose: upstream of the modular multiplier; produces the (q, mu) pair it consumes, with mu = floor(2^64/q).
REQ-012 States: IDLE, CALC, DONE; one-hot or binary at implementer's choice.
REQ-013 Accept = in_valid & in_ready; on accept, q is latched into q_out and a 65-bit remainder register and a 65-bit quotient register are cleared.
REQ-014 Accept with q_in >= 2: IDLE->CALC; iteration counter loaded with 64.
REQ-015 Accept with q_in < 2: IDLE->DONE directly; mu_out = 64'hFFFF_FFFF_FFFF_FFFF, err = 1.
REQ-016 CALC performs one restoring-division step per cycle over dividend 2^64 (bit 64 = 1, bits 63..0 = 0), MSB first: rem = {rem[63:0], dbit}; if rem >= q then rem -= q and qbit = 1, else qbit = 0; quotient shifts left taking qbit.
REQ-017 CALC lasts exactly 65 cycles (counter 64 down to 0), then ->DONE; mu_out = quotient[63:0] (bit 64 is always 0 for q >= 2), err = 0.
REQ-018 Latency: out_valid rises 66 cycles after the accepting edge for a full computation; 1 cycle for the q < 2 path.
REQ-019 DONE: out_valid = 1; q_out, mu_out, err stable while out_valid & !out_ready.
REQ-020 DONE with out_ready = 1: ->IDLE next edge; out_valid drops; new request not accepted in the same cycle (in_ready is 0 in DONE).
REQ-021 in_valid while busy is ignored; q_in changes during CALC have no effect.
REQ-022 mu_out, q_out, err are don't-care when out_valid = 0 but are registered (no combinational path from q_in).

Reset
REQ-023 rst_n low forces, asynchronously: state IDLE, in_ready 1 after release, out_valid 0, q_out 0, mu_out 0, err 0, counter 0, remainder 0.
REQ-024 Reset asserted mid-CALC or in DONE aborts the operation; no result is produced after release.

Configuration
REQ-025 Macro BARRETT_MU_CACHE_EN: when defined, the block holds the last successfully computed (q, mu) pair and a cache-valid bit cleared by reset.
REQ-026 With BARRETT_MU_CACHE_EN, an accepted q_in equal to the cached q (cache valid, q >= 2) goes IDLE->DONE directly with cached mu, err = 0, 1-cycle latency; cache updated at every CALC->DONE.
REQ-027 Without BARRETT_MU_CACHE_EN, every q >= 2 takes the full 66-cycle path; no cache storage synthesised.

Verification
REQ-028 q_in=2, out_ready=1 -> out_valid 66 cycles after accept, mu_out=64'h8000_0000_0000_0000, err=0.
REQ-029 q_in=3 -> mu_out=64'h5555_5555_5555_5555; q_in=64'h8000_0000_0000_0000 -> mu_out=2; q_in=64'hFFFF_FFFF_0000_0001 -> mu_out=1.
REQ-030 q_in=0 and q_in=1 -> out_valid 1 cycle after accept, err=1, mu_out=all ones.
REQ-031 out_ready held 0 for 10 cycles in DONE -> out_valid, q_out, mu_out stable; in_ready stays 0; in_valid pulses ignored.
REQ-032 rst_n pulsed low at CALC cycle 30 -> outputs at reset values immediately; no out_valid after release until a new accept.
REQ-033 With BARRETT_MU_CACHE_EN: q=3 then q=3 again -> second result in 1 cycle with mu=64'h5555_5555_5555_5555; without macro -> 66 cycles.

Source files
------------

// File: rtl/barrett_mu_gen.sv
// Barrett constant generator: mu = floor(2^64 / q) by a 65-step restoring division.
// Optional macro BARRETT_MU_CACHE_EN keeps the last (q, mu) pair and short-circuits repeats.
module barrett_mu_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] q_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] q_out,
    output logic [63:0] mu_out,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    logic [64:0] rem;
    logic [64:0] quot;
    logic [6:0]  cnt;

    logic [64:0] rem_shift;
    logic [64:0] rem_next;
    logic [64:0] quot_next;
    logic        q_bit;

    // The dividend 2^64 has only bit 64 set, which is fed in on the first step (cnt == 64).
    always_comb begin
        rem_shift = (rem << 1) | {64'd0, (cnt == 7'd64)};
        q_bit     = (rem_shift >= {1'b0, q_out});
        rem_next  = q_bit ? (rem_shift - {1'b0, q_out}) : rem_shift;
        quot_next = (quot << 1) | {64'd0, q_bit};
    end

    logic        cache_hit;
    logic [63:0] cache_mu;

`ifdef BARRETT_MU_CACHE_EN
    logic        cache_valid;
    logic [63:0] cache_q;

    assign cache_hit = cache_valid && (q_in == cache_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_valid <= 1'b0;
            cache_q     <= '0;
            cache_mu    <= '0;
        end else if (state == CALC && cnt == 7'd0) begin
            cache_valid <= 1'b1;
            cache_q     <= q_out;
            cache_mu    <= quot_next[63:0];
        end
    end
`else
    assign cache_hit = 1'b0;
    assign cache_mu  = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            q_out     <= '0;
            mu_out    <= '0;
            err       <= 1'b0;
            rem       <= '0;
            quot      <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        q_out    <= q_in;
                        rem      <= '0;
                        quot     <= '0;
                        if (q_in < 64'd2) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            mu_out    <= '1;
                            err       <= 1'b1;
                        end else if (cache_hit) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            mu_out    <= cache_mu;
                            err       <= 1'b0;
                        end else begin
                            state <= CALC;
                            cnt   <= 7'd64;
                        end
                    end
                end
                CALC: begin
                    rem  <= rem_next;
                    quot <= quot_next;
                    // Quotient bit 64 is always zero for q >= 2, so only the low word is kept.
                    if (cnt == 7'd0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        mu_out    <= quot_next[63:0];
                        err       <= 1'b0;
                    end else begin
                        cnt <= cnt - 7'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_barrett_mu_gen.sv
// Self-checking bench for barrett_mu_gen: random and directed moduli against an arithmetic model.
module tb_barrett_mu_gen;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] q_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] q_out;
    logic [63:0] mu_out;
    logic        err;

    int checks = 0;
    int errors = 0;

`ifdef BARRETT_MU_CACHE_EN
    bit          m_cache_valid = 1'b0;
    logic [63:0] m_cache_q     = '0;
`endif

    barrett_mu_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q_in      (q_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q_out     (q_out),
        .mu_out    (mu_out),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [63:0] model_mu(input logic [63:0] q);
        logic [64:0] two64;
        logic [64:0] quo;
        two64 = 65'd1 << 64;
        quo   = two64 / {1'b0, q};
        return quo[63:0];
    endfunction

    // Issue one request, wait for the result, optionally hold it for a while, then accept it.
    task automatic run_request(input logic [63:0] q, input bit scramble, input int hold);
        logic [63:0] exp_mu;
        logic        exp_err;
        int          exp_lat;
        int          lat;
        logic [63:0] held_q;
        logic [63:0] held_mu;
        bit          full_path;

        full_path = 1'b0;
        if (q < 64'd2) begin
            exp_mu  = '1;
            exp_err = 1'b1;
            exp_lat = 1;
        end else begin
            exp_mu  = model_mu(q);
            exp_err = 1'b0;
            exp_lat = 66;
            full_path = 1'b1;
`ifdef BARRETT_MU_CACHE_EN
            if (m_cache_valid && m_cache_q == q) begin
                exp_lat   = 1;
                full_path = 1'b0;
            end
`endif
        end

        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL in_ready_before_accept got %b exp 1", in_ready);
        end
        in_valid = 1'b1;
        q_in     = q;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            if (scramble) begin
                q_in     = {$urandom, $urandom};
                in_valid = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;

        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("[TB] FAIL latency q=%h got %0d exp %0d", q, lat, exp_lat);
        end
        checks++;
        if (q_out !== q) begin
            errors++;
            $display("[TB] FAIL q_out got %h exp %h", q_out, q);
        end
        checks++;
        if (mu_out !== exp_mu) begin
            errors++;
            $display("[TB] FAIL mu_out q=%h got %h exp %h", q, mu_out, exp_mu);
        end
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("[TB] FAIL err q=%h got %b exp %b", q, err, exp_err);
        end

        held_q  = q;
        held_mu = exp_mu;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            q_in     = {$urandom, $urandom};
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || q_out !== held_q || mu_out !== held_mu) begin
                errors++;
                $display("[TB] FAIL hold cycle %0d got v=%b r=%b q=%h mu=%h exp v=1 r=0 q=%h mu=%h",
                         i, out_valid, in_ready, q_out, mu_out, held_q, held_mu);
            end
        end
        in_valid = 1'b0;

        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL handshake got v=%b r=%b exp v=0 r=1", out_valid, in_ready);
        end

`ifdef BARRETT_MU_CACHE_EN
        if (full_path) begin
            m_cache_valid = 1'b1;
            m_cache_q     = q;
        end
`else
        if (full_path) begin
            exp_lat = 66;
        end
`endif
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        q_in      = '0;
        #12;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || q_out !== 64'd0 || mu_out !== 64'd0 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state got r=%b v=%b q=%h mu=%h e=%b exp r=1 v=0 q=0 mu=0 e=0",
                     in_ready, out_valid, q_out, mu_out, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        run_request(64'd2, 1'b0, 0);
        run_request(64'd3, 1'b0, 0);
        run_request(64'h8000_0000_0000_0000, 1'b0, 0);
        run_request(64'hFFFF_FFFF_0000_0001, 1'b0, 0);
        // Hand-derived constants, independent of the model function.
        checks++;
        if (model_mu(64'd3) !== 64'h5555_5555_5555_5555 || model_mu(64'h8000_0000_0000_0000) !== 64'd2) begin
            errors++;
            $display("[TB] FAIL model_sanity got %h exp 5555555555555555", model_mu(64'd3));
        end
    endtask

    task automatic test_small_q;
        run_request(64'd0, 1'b0, 0);
        run_request(64'd1, 1'b0, 0);
    endtask

    task automatic test_random;
        logic [63:0] q;
        for (int n = 0; n < 8; n++) begin
            q = {$urandom, $urandom} >> $urandom_range(0, 62);
            if (q < 64'd2) q = q + 64'd2;
            run_request(q, 1'b1, 0);
        end
    endtask

    task automatic test_hold;
        run_request(64'h0000_0000_0000_0007, 1'b1, 10);
    endtask

    task automatic test_abort;
        bit seen;
        @(negedge clk);
        in_valid = 1'b1;
        q_in     = 64'h1234_5678_9ABC_DEF1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || q_out !== 64'd0 || mu_out !== 64'd0 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_reset got v=%b q=%h mu=%h e=%b exp all zero", out_valid, q_out, mu_out, err);
        end
`ifdef BARRETT_MU_CACHE_EN
        m_cache_valid = 1'b0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_no_result got seen=%b r=%b exp seen=0 r=1", seen, in_ready);
        end
    endtask

    task automatic test_back_to_back;
        run_request(64'd3, 1'b0, 0);
        run_request(64'd3, 1'b0, 0);
        run_request(64'd5, 1'b0, 0);
        run_request(64'd3, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_small_q();
        test_random();
        test_hold();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
